ccff_chain_loader: RTL and testbench

- Programming-side master for the fabric configuration chain: accepts bitstream words over a valid/ready stream and serializes them, MSB first, onto the chain head (ccff_head) of the first tile.
- Monitors the chain tail (ccff_tail of the last tile). An optional second pass re-shifts the same stream and checks the tail for readback errors.
- Holds IO isolation asserted (IO_ISOL_N=0) from start until a clean load completes.
- Sits at fabric top, between the SoC bitstream DMA and the tile chain.

---
 rtl/ccff_pkg.sv | 26 ++
 rtl/ccff_word_serializer.sv | 106 ++++++++++
 rtl/ccff_chain_loader.sv | 147 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and elaboration-time helpers for the configuration chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int words_per_pass(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits of the final word of a pass that actually reach the chain.
  function automatic int last_word_bits(input int chain_len, input int word_w);
    int rem_bits;
    rem_bits = chain_len % word_w;
    return (rem_bits == 0) ? word_w : rem_bits;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer and MSB-first shifter feeding the chain head; tracks word position
// within a pass so the final word is truncated and nothing is taken after the last pass.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic              two_pass,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              head_o,
  output logic              shift_en_o
);

  localparam int NWORDS    = words_per_pass(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
  localparam int WCW       = $clog2(NWORDS + 1);
  localparam int RW        = $clog2(WORD_W);
  localparam logic [RW-1:0]  REM_FULL = RW'(WORD_W - 1);
  localparam logic [RW-1:0]  REM_LAST = RW'(LAST_BITS - 1);
  localparam logic [WCW-1:0] WLAST    = WCW'(NWORDS - 1);

  logic [WORD_W-1:0] buf_q, buf_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic              pass_q, pass_d;
  logic              stop_q, stop_d;
  logic              head_q, head_d;
  logic              shift_q, shift_d;
  logic              xfer_s;

  // rem_q counts bits still waiting in buf_q; when it is zero the head register
  // holds the last used bit, so a new word can be taken without a bubble.
  assign s_ready    = en && (rem_q == {RW{1'b0}}) && !stop_q;
  assign xfer_s     = s_ready && s_valid;
  assign head_o     = head_q;
  assign shift_en_o = shift_q;

  // Next-state for buffer, bit index, pass tracking and the head/shift registers
  always_comb begin
    buf_d      = buf_q;
    rem_d      = rem_q;
    word_cnt_d = word_cnt_q;
    pass_d     = pass_q;
    stop_d     = stop_q;
    head_d     = head_q;
    shift_d    = 1'b0;
    if (clear) begin
      rem_d      = {RW{1'b0}};
      word_cnt_d = {WCW{1'b0}};
      pass_d     = 1'b0;
      stop_d     = 1'b0;
    end else if (xfer_s) begin
      head_d  = s_data[WORD_W-1];
      buf_d   = s_data << 1;
      shift_d = 1'b1;
      if (word_cnt_q == WLAST) begin
        rem_d      = REM_LAST;
        word_cnt_d = {WCW{1'b0}};
        if (pass_q || !two_pass) begin
          stop_d = 1'b1;
        end else begin
          pass_d = 1'b1;
        end
      end else begin
        rem_d      = REM_FULL;
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end else if (rem_q != {RW{1'b0}}) begin
      head_d  = buf_q[WORD_W-1];
      buf_d   = buf_q << 1;
      rem_d   = rem_q - RW'(1);
      shift_d = 1'b1;
    end else begin
      shift_d = 1'b0;
    end
  end

  // Serializer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= {WORD_W{1'b0}};
      rem_q      <= {RW{1'b0}};
      word_cnt_q <= {WCW{1'b0}};
      pass_q     <= 1'b0;
      stop_q     <= 1'b0;
      head_q     <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      rem_q      <= rem_d;
      word_cnt_q <= word_cnt_d;
      pass_q     <= pass_d;
      stop_q     <= stop_d;
      head_q     <= head_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration chain master: load FSM, per-pass bit counter, readback compare
// against the chain tail and IO isolation control.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              IO_ISOL_N,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          verify_q, verify_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          isol_q, isol_d;
  logic          clear_s;
  logic          last_shift_s;
  logic          mismatch_s;

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .clk        (prog_clk),
    .rst        (pReset),
    .en         (busy_q),
    .clear      (clear_s),
    .two_pass   (verify_q),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .head_o     (ccff_head),
    .shift_en_o (ccff_shift_en)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign IO_ISOL_N = isol_q;

  // FSM next-state, pass bit counter and readback compare
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    verify_d  = verify_q;
    done_d    = done_q;
    error_d   = error_q;
    isol_d    = isol_q;
    clear_s   = 1'b0;
    // The tail bit now leaving the chain entered it exactly CHAIN_LEN shifts ago.
    mismatch_s   = ccff_tail ^ ccff_head;
    last_shift_s = ccff_shift_en && (bit_cnt_q == CNT_LAST);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          verify_d  = verify_en;
          bit_cnt_d = {CW{1'b0}};
          done_d    = 1'b0;
          error_d   = 1'b0;
          isol_d    = 1'b0;
          clear_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (last_shift_s) begin
          bit_cnt_d = {CW{1'b0}};
          if (verify_q) begin
            state_d = S_VERIFY;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            isol_d  = ~error_q;
          end
        end else if (ccff_shift_en) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      S_VERIFY: begin
        if (ccff_shift_en) begin
          error_d = error_q | mismatch_s;
        end else begin
          error_d = error_q;
        end
        if (last_shift_s) begin
          bit_cnt_d = {CW{1'b0}};
          state_d   = S_DONE;
          done_d    = 1'b1;
          isol_d    = ~(error_q | mismatch_s);
        end else if (ccff_shift_en) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_VERIFY);
  end

  // Control and status registers
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= {CW{1'b0}};
      verify_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      isol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      verify_q  <= verify_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      isol_q    <= isol_d;
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: expected chain bits queued by the stimulus, popped by a monitor on every shift.
module tb_ccff_chain_loader;

  localparam int CL = 40;
  localparam int WW = 16;

  logic          prog_clk  = 1'b0;
  logic          pReset    = 1'b1;
  logic          start     = 1'b0;
  logic          verify_en = 1'b0;
  logic [WW-1:0] s_data    = '0;
  logic          s_valid   = 1'b0;
  logic          s_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic          IO_ISOL_N, busy, done, error;

  logic [CL-1:0] chain_q = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_q[$];
  int shift_cnt, first_shift, last_shift, first_acc, done_cyc;
  bit done_seen;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .verify_en     (verify_en),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .IO_ISOL_N     (IO_ISOL_N),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  // Fabric chain model: plain shift register clocked by the shift enable.
  assign ccff_tail = chain_q[CL-1];
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (ccff_shift_en) chain_q <= {chain_q[CL-2:0], ccff_head};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    shift_cnt = 0; first_shift = -1; last_shift = -1;
    first_acc = -1; done_cyc = -1; done_seen = 1'b0;
  endtask

  // Monitor: pop one expected bit per shifting cycle and record timing.
  initial begin
    bit eb;
    clear_stats();
    forever begin
      @(negedge prog_clk);
      if (pReset) begin
        exp_q.delete();
        clear_stats();
      end else if (start && !busy) begin
        clear_stats();
      end else begin
        if (s_ready && s_valid && first_acc < 0) first_acc = cyc;
        if (ccff_shift_en) begin
          if (first_shift < 0) first_shift = cyc;
          last_shift = cyc;
          shift_cnt++;
          check("shift_has_data", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            check("head_bit", 32'(ccff_head), 32'(eb));
          end
        end
        if (done && !done_seen) begin
          done_seen = 1'b1;
          done_cyc  = cyc;
        end
      end
    end
  end

  // A pass is three words; only the top CL bits of the concatenation reach the chain.
  task automatic push_pass(input logic [47:0] p);
    for (int k = 0; k < CL; k++) exp_q.push_back(p[47-k]);
  endtask

  task automatic pulse_start(input bit v);
    @(posedge prog_clk); #1;
    start = 1'b1; verify_en = v;
    @(posedge prog_clk); #1;
    start = 1'b0; verify_en = 1'($urandom);
  endtask

  task automatic drive_word(input logic [WW-1:0] w);
    int t;
    t = 0;
    s_data = w; s_valid = 1'b1;
    @(negedge prog_clk);
    while (!s_ready && t < 300) begin
      @(negedge prog_clk);
      t++;
    end
    if (!s_ready) check("accept_timeout", 32'(s_ready), 32'd1);
    @(posedge prog_clk); #1;
    s_valid = 1'b0; s_data = WW'($urandom);
  endtask

  task automatic stall(input int len);
    int t;
    t = 0;
    if (len > 0) begin
      @(negedge prog_clk);
      while (!s_ready && t < 300) begin
        @(negedge prog_clk);
        t++;
      end
      repeat (len) @(posedge prog_clk);
      #1;
    end
  endtask

  task automatic send_pass(input logic [47:0] p, input int st_idx, input int st_len, input bit junk);
    for (int i = 0; i < 3; i++) begin
      if (junk && i == 1) pulse_start(1'b1);
      if (i == st_idx) stall(st_len);
      drive_word(p[47-16*i -: 16]);
    end
  endtask

  task automatic run_op(input bit v, input logic [47:0] p1, input logic [47:0] p2,
                        input int st_idx, input int st_len, input bit junk);
    bit exp_err;
    int t;
    exp_err = v && (p1[47:8] != p2[47:8]);
    push_pass(p1);
    if (v) push_pass(p2);
    pulse_start(v);
    send_pass(p1, st_idx, st_len, junk);
    if (v) send_pass(p2, 0, 0, 1'b0);
    t = 0;
    while (!done && t < 400) begin
      @(negedge prog_clk);
      t++;
    end
    check("done_raised", 32'(done), 32'd1);
    @(negedge prog_clk);
    check("shift_count", 32'(shift_cnt), v ? 32'd80 : 32'd40);
    check("stall_cycles", 32'(last_shift - first_shift + 1 - shift_cnt), 32'(st_len));
    check("first_shift_latency", 32'(first_shift - first_acc), 32'd1);
    check("done_latency", 32'(done_cyc - last_shift), 32'd1);
    check("idle_status", {29'd0, busy, s_ready, ccff_shift_en}, 32'd0);
    check("error_flag", 32'(error), 32'(exp_err));
    check("io_isol_n", 32'(IO_ISOL_N), 32'(!exp_err));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] pa, pm, pr, pf;
    bit v;
    int t;
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b0;
    repeat (5) begin
      @(negedge prog_clk);
      check("idle_outputs", {25'd0, s_ready, ccff_head, ccff_shift_en, IO_ISOL_N, busy, done, error}, 32'd0);
    end

    pa = {16'hA5F0, 16'h1234, 16'hC3FF};
    pm = {16'hA1F0, 16'h1234, 16'hC3FF};
    run_op(1'b0, pa, pa, 0, 0, 1'b0);
    run_op(1'b0, pa, pa, 2, 4, 1'b0);
    run_op(1'b1, pa, pa, 0, 0, 1'b0);
    run_op(1'b1, pa, pm, 0, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      pr = {16'($urandom), 16'($urandom), 16'($urandom)};
      v  = 1'($urandom_range(1, 0));
      pf = pr;
      if ($urandom_range(1, 0) == 1) pf[$urandom_range(47, 0)] ^= 1'b1;
      run_op(v, pr, pf, $urandom_range(2, 1), $urandom_range(5, 0), 1'($urandom));
    end

    // Abort mid-load, then a clean restart with start pulses while busy.
    push_pass(pa);
    pulse_start(1'b0);
    drive_word(pa[47:32]);
    drive_word(pa[31:16]);
    t = 0;
    while (shift_cnt < 20 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check("abort_point_reached", 32'(shift_cnt >= 20), 32'd1);
    pReset = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1 pReset = 1'b0;
    repeat (3) begin
      @(negedge prog_clk);
      check("post_abort_outputs", {25'd0, s_ready, ccff_head, ccff_shift_en, IO_ISOL_N, busy, done, error}, 32'd0);
    end
    pr = {16'($urandom), 16'($urandom), 16'($urandom)};
    run_op(1'b0, pr, pr, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
